adc_block_sequencer: RTL
========================

ADC_BLOCK_SEQUENCER -- requirements
Module: adc_block_sequencer

Interface
REQ-001 Parameter STARTUP_CYCLES, default 240000, sys_clk cycles to hold the ADC off after PLL lock is seen.
REQ-002 Parameter DISCARD_N, default 2, ADC samples dropped after each ADC enable (covers power-on bit misalignment).
REQ-003 Parameter BLOCK_LEN, default 205, samples per analysis block.
REQ-004 Parameter DRAIN_TIMEOUT, default 65535, max cycles to wait for a result after a block's last sample.
REQ-005 sys_clk  in  1  single clock for all logic.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 pll_lock  in  1  PLL lock, asynchronous to sys_clk.
REQ-008 adc_en  out  1  enable to the ADC serial interface.
REQ-009 adc_done  in  1  one-cycle pulse: adc_data valid.
REQ-010 adc_data  in  8  ADC sample.
REQ-011 smp_valid  out  1  one-cycle pulse: smp_data forwarded to the detector.
REQ-012 smp_data  out  8  registered sample.
REQ-013 blk_first  out  1  qualifies smp_valid: first sample of the block.
REQ-014 blk_last  out  1  qualifies smp_valid: last sample of the block.
REQ-015 mag_ready  in  1  detector result pulse.
REQ-016 blk_count  out  16  completed blocks, wraps 0xFFFF->0.
REQ-017 drop_count  out  16  samples dropped in DRAIN, saturates at 0xFFFF.
REQ-018 err_lock_lost  out  1  sticky: lock fell after ADC enable.
REQ-019 err_timeout  out  1  sticky: DRAIN timed out.

Function
REQ-020 pll_lock shall pass through a 2-flop synchronizer; lock_s denotes its output.
REQ-021 States shall be IDLE, WARMUP, DISCARD, RUN, DRAIN; adc_en = 1 exactly in DISCARD, RUN and DRAIN.
REQ-022 IDLE->WARMUP when lock_s=1; the counter clears on entry.
REQ-023 WARMUP->DISCARD once STARTUP_CYCLES cycles have elapsed in WARMUP.
REQ-024 In DISCARD, adc_done pulses shall be dropped silently; ->RUN after the DISCARD_N-th pulse (DISCARD_N=0 skips directly to RUN).
REQ-025 In RUN, each adc_done shall produce smp_valid exactly 1 cycle later, with smp_data=adc_data captured on the pulse cycle.
REQ-026 blk_first shall be asserted with sample index 0 and blk_last with index BLOCK_LEN-1; both shall be 0 when smp_valid=0.
REQ-027 After the blk_last sample, RUN->DRAIN and the sample index returns to 0.
REQ-028 In DRAIN, adc_done pulses shall be dropped and drop_count incremented.
REQ-029 DRAIN->RUN on mag_ready, with blk_count incremented.
REQ-030 If DRAIN_TIMEOUT cycles elapse without mag_ready: set err_timeout, leave blk_count unchanged, DRAIN->RUN.
REQ-031 mag_ready outside DRAIN shall be ignored.
REQ-032 adc_done and mag_ready in the same DRAIN cycle: mag_ready wins the transition; the sample shall be dropped and counted.
REQ-033 lock_s=0 in any non-IDLE state shall force IDLE on the next edge, drop adc_en, suppress any pending smp_valid and clear the sample index.
REQ-034 err_lock_lost shall be set only if the lock loss of REQ-033 occurs while adc_en=1.
REQ-035 After REQ-033, re-lock shall repeat WARMUP and DISCARD in full.

Reset
REQ-036 rst shall force IDLE, clear both synchronizer flops, all counters and the sample index, and drive every output to 0.
REQ-037 rst asserted mid-block shall discard the partial block with no further smp_valid.

Structure
REQ-038 The state encoding and default parameter values shall live in a shared package, adc_seq_pkg.
REQ-039 The synchronizer shall be a sub-module, sync_2ff, reusable for other cross-domain flags.

Verification (STARTUP_CYCLES=16, DISCARD_N=2, BLOCK_LEN=4, DRAIN_TIMEOUT=32)
REQ-040 Raise lock at cycle 0 -> adc_en rises at cycle 2+1+16 ±1; first 2 adc_done produce no smp_valid.
REQ-041 6 adc_done with data 0x10..0x15 after enable -> 4 smp_valid carrying 0x12..0x15, blk_first on 0x12, blk_last on 0x15.
REQ-042 Pulse mag_ready 5 cycles into DRAIN with 1 adc_done in between -> drop_count=1, blk_count=1, next sample carries blk_first.
REQ-043 No mag_ready for 32 cycles in DRAIN -> err_timeout=1, blk_count=0, RUN resumes.
REQ-044 Drop lock during RUN after sample 2 -> adc_en=0 within 3 cycles, err_lock_lost=1; re-lock -> full 16-cycle warmup plus 2 discards; the first block restarts at index 0.
REQ-045 Assert rst mid-DRAIN -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared state encoding and default timing parameters for the ADC block sequencer.
// Pure declarations: no logic, no latency, no flow control.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_DISCARD = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4
    } seq_state_t;

    localparam int DEF_STARTUP_CYCLES = 240000;
    localparam int DEF_DISCARD_N      = 2;
    localparam int DEF_BLOCK_LEN      = 205;
    localparam int DEF_DRAIN_TIMEOUT  = 65535;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into the clk domain.
// Latency 2 clk edges; no flow control.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_block_sequencer.sv
// Powers up the ADC after PLL lock, drops warm-up samples, and frames the sample stream into blocks.
// Samples forwarded 1 cycle after adc_done; no backpressure: samples arriving while a block result is pending are dropped and counted.
module adc_block_sequencer
    import adc_seq_pkg::*;
#(
    parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int DISCARD_N      = DEF_DISCARD_N,
    parameter int BLOCK_LEN      = DEF_BLOCK_LEN,
    parameter int DRAIN_TIMEOUT  = DEF_DRAIN_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        pll_lock,
    output logic        adc_en,
    input  logic        adc_done,
    input  logic [7:0]  adc_data,
    output logic        smp_valid,
    output logic [7:0]  smp_data,
    output logic        blk_first,
    output logic        blk_last,
    input  logic        mag_ready,
    output logic [15:0] blk_count,
    output logic [15:0] drop_count,
    output logic        err_lock_lost,
    output logic        err_timeout
);

    seq_state_t  state;
    logic        lock_s;
    logic [31:0] cnt;
    logic [15:0] idx;

    sync_2ff u_lock_sync (
        .clk (sys_clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            adc_en        <= 1'b0;
            smp_valid     <= 1'b0;
            smp_data      <= '0;
            blk_first     <= 1'b0;
            blk_last      <= 1'b0;
            blk_count     <= '0;
            drop_count    <= '0;
            err_lock_lost <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            smp_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            // Lock loss overrides everything, including a sample captured this cycle.
            if (state != ST_IDLE && !lock_s) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                idx    <= '0;
                adc_en <= 1'b0;
                if (adc_en)
                    err_lock_lost <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (lock_s) begin
                            state <= ST_WARMUP;
                            cnt   <= '0;
                        end
                    end
                    ST_WARMUP: begin
                        if (cnt == 32'(STARTUP_CYCLES - 1)) begin
                            cnt    <= '0;
                            adc_en <= 1'b1;
                            state  <= (DISCARD_N == 0) ? ST_RUN : ST_DISCARD;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    ST_DISCARD: begin
                        if (adc_done) begin
                            if (cnt == 32'(DISCARD_N - 1)) begin
                                cnt   <= '0;
                                state <= ST_RUN;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (adc_done) begin
                            smp_valid <= 1'b1;
                            smp_data  <= adc_data;
                            blk_first <= (idx == 16'd0);
                            blk_last  <= (idx == 16'(BLOCK_LEN - 1));
                            if (idx == 16'(BLOCK_LEN - 1)) begin
                                idx   <= '0;
                                cnt   <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                idx <= idx + 16'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (adc_done && drop_count != 16'hFFFF)
                            drop_count <= drop_count + 16'd1;
                        if (mag_ready) begin
                            blk_count <= blk_count + 16'd1;
                            cnt       <= '0;
                            state     <= ST_RUN;
                        end else if (cnt == 32'(DRAIN_TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            cnt         <= '0;
                            state       <= ST_RUN;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        adc_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
